// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue in front of decode.
// Owns the fetch PC and issues one 32-bit read per accepted request. Responses
// come back in order and fill the queue slots; decode pops them in order
// through a valid/ready handshake. A redirect flushes the queue and counts
// responses still outstanding so that they are dropped when they arrive.
//
// Ports:
//   i_clk, i_rst                       clock, synchronous active-high reset
//   o_mem_req_valid/i_mem_req_ready    fetch request handshake
//   o_mem_req_addr                     fetch address (current PC)
//   i_mem_rsp_valid/i_mem_rsp_data     in-order response, never stalled
//   i_redirect/i_redirect_pc           flush and restart fetch
//   o_instr_valid/i_instr_ready        decode handshake
//   o_instr/o_instr_pc                 instruction word and its PC

// One queue slot: PC captured at request time, data captured at response time.
module fetch_queue_slot #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              pc_we,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              data_we,
  input  logic [31:0]       data_in,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       data
);
  always_ff @(posedge clk) begin
    if (pc_we)   pc   <= pc_in;
    if (data_we) data <= data_in;
  end
endmodule

module fetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  input  logic              i_mem_rsp_valid,
  input  logic [31:0]       i_mem_rsp_data,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_instr,
  output logic [ADDR_W-1:0] o_instr_pc
);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_X = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [PW-1:0]     rd, fill, alloc, discard;
  logic [PW-1:0]     occupancy, pending;
  logic [PW:0]       inflight;
  logic              req_fire, rsp_drop, rsp_take, pop;

  logic [DEPTH-1:0][ADDR_W-1:0] slot_pc;
  logic [DEPTH-1:0][31:0]       slot_data;
  logic [DEPTH-1:0]             pc_we, data_we;

  assign occupancy = alloc - rd;
  assign pending   = alloc - fill;
  // Discarded responses still occupy memory-side capacity, so they count here.
  assign inflight  = {1'b0, pending} + {1'b0, discard};

  assign o_mem_req_valid = !i_rst && !i_redirect &&
                           ({1'b0, occupancy} < DEPTH_X) && (inflight < DEPTH_X);
  assign o_mem_req_addr  = pc;
  assign req_fire        = o_mem_req_valid && i_mem_req_ready;

  assign rsp_drop = i_mem_rsp_valid && (discard != '0);
  assign rsp_take = i_mem_rsp_valid && (discard == '0) && (pending != '0) && !i_redirect;

  assign o_instr_valid = !i_rst && (rd != fill);
  assign pop           = o_instr_valid && i_instr_ready;
  assign o_instr       = slot_data[rd[IW-1:0]];
  assign o_instr_pc    = slot_pc[rd[IW-1:0]];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign pc_we[g]   = req_fire && (alloc[IW-1:0] == IW'(g));
    assign data_we[g] = rsp_take && (fill[IW-1:0] == IW'(g));
    fetch_queue_slot #(.ADDR_W(ADDR_W)) u_slot (
      .clk     (i_clk),
      .pc_we   (pc_we[g]),
      .pc_in   (pc),
      .data_we (data_we[g]),
      .data_in (i_mem_rsp_data),
      .pc      (slot_pc[g]),
      .data    (slot_data[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc      <= RESET_PC;
      rd      <= '0;
      fill    <= '0;
      alloc   <= '0;
      discard <= '0;
    end else if (i_redirect) begin
      // Low two bits of the target are forced to zero (word aligned fetch).
      pc      <= i_redirect_pc & ~ADDR_W'(3);
      rd      <= '0;
      fill    <= '0;
      alloc   <= '0;
      // The response arriving this very cycle is dropped now, not counted.
      if (i_mem_rsp_valid && (inflight != '0))
        discard <= PW'(inflight - (PW+1)'(1));
      else
        discard <= PW'(inflight);
    end else begin
      if (req_fire) begin
        alloc <= alloc + PW'(1);
        pc    <= pc + ADDR_W'(4);
      end
      if (rsp_drop) discard <= discard - PW'(1);
      if (rsp_take) fill    <= fill + PW'(1);
      if (pop)      rd      <= rd + PW'(1);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: an in-order memory with variable latency lives in the
// bench, and a stream model checks that decode sees PC, PC+4, ... from the last
// reset/redirect target, each carrying the word memory holds at that PC.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          ADDR_W   = 64;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic [ADDR_W-1:0] o_mem_req_addr;
  logic              i_mem_rsp_valid;
  logic [31:0]       i_mem_rsp_data;
  logic              i_redirect;
  logic [ADDR_W-1:0] i_redirect_pc;
  logic              o_instr_valid;
  logic              i_instr_ready;
  logic [31:0]       o_instr;
  logic [ADDR_W-1:0] o_instr_pc;

  fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_addr  (o_mem_req_addr),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_instr_valid   (o_instr_valid),
    .i_instr_ready   (i_instr_ready),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, lat = 1, last_due = 0;
  int nfire = 0, npop = 0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  logic [63:0] exp_req, exp_out, first_pop_pc;
  int          occ;
  logic        s_req_valid, s_instr_valid, s_rsp_valid;
  logic [63:0] s_req_addr;

  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present the memory response, sample outputs, update the
  // model, then advance to the next falling edge.
  task automatic tick();
    logic req_fire, pop;
    if (!i_rst && mq_due.size() > 0 && mq_due[0] <= cyc) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = memf(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      i_mem_rsp_valid = 1'b0;
      i_mem_rsp_data  = $urandom;
    end
    #1;
    s_req_valid   = o_mem_req_valid;
    s_req_addr    = o_mem_req_addr;
    s_instr_valid = o_instr_valid;
    s_rsp_valid   = i_mem_rsp_valid;
    req_fire      = o_mem_req_valid && i_mem_req_ready;
    pop           = o_instr_valid && i_instr_ready;
    if (i_rst) begin
      chk("rst_req_valid", {63'b0, o_mem_req_valid}, 64'd0);
      chk("rst_instr_valid", {63'b0, o_instr_valid}, 64'd0);
      mq_addr.delete(); mq_due.delete(); last_due = 0;
      exp_req = RESET_PC; exp_out = RESET_PC; occ = 0;
    end else if (i_redirect) begin
      chk("redir_no_req", {63'b0, o_mem_req_valid}, 64'd0);
      exp_req = i_redirect_pc & ~64'd3; exp_out = exp_req; occ = 0;
    end else begin
      if (req_fire) begin
        chk("req_addr", o_mem_req_addr, exp_req);
        last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        mq_addr.push_back(o_mem_req_addr);
        mq_due.push_back(last_due);
        exp_req += 64'd4; occ++; nfire++;
      end
      if (pop) begin
        chk("instr_pc", o_instr_pc, exp_out);
        chk("instr_data", {32'b0, o_instr}, {32'b0, memf(exp_out)});
        if (npop == 0) first_pop_pc = o_instr_pc;
        exp_out += 64'd4; occ--; npop++;
      end
      chk("occ_bound", {63'b0, occ <= DEPTH}, 64'd1);
      chk("inflight_bound", {63'b0, mq_due.size() <= DEPTH}, 64'd1);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic wait_first_pop(input string tag, input logic [63:0] pc);
    npop = 0;
    for (int k = 0; k < 40 && npop == 0; k++) tick();
    chk({tag, "_seen"}, {63'b0, npop > 0}, 64'd1);
    if (npop > 0) chk(tag, first_pop_pc, pc);
  endtask

  initial begin
    i_rst = 1'b1; i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b1;
    @(negedge i_clk);
    repeat (2) tick();

    // Streaming: 1-cycle memory, decode always ready.
    i_rst = 1'b0; lat = 1;
    tick();
    chk("first_req_valid", {63'b0, s_req_valid}, 64'd1);
    chk("first_req_addr", s_req_addr, RESET_PC);
    for (int k = 1; k < 20; k++) begin
      tick();
      if (k >= 2) chk("stream_valid", {63'b0, s_instr_valid}, 64'd1);
    end

    // Decode stalled: fills exactly DEPTH slots, then one pop frees one slot.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_instr_ready = 1'b0; nfire = 0;
    repeat (12) tick();
    chk("stall_fires", 64'(nfire), 64'(DEPTH));
    chk("stall_req_valid", {63'b0, s_req_valid}, 64'd0);
    i_instr_ready = 1'b1; nfire = 0;
    tick();
    chk("release_pop", {63'b0, s_instr_valid}, 64'd1);
    i_instr_ready = 1'b0;
    repeat (8) tick();
    chk("release_fires", 64'(nfire), 64'd1);

    // Redirect with three requests outstanding and no response that cycle.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_instr_ready = 1'b1; lat = 4; nfire = 0;
    repeat (3) tick();
    chk("redir3_fires", 64'(nfire), 64'd3);
    i_mem_req_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 64'h1002;
    tick();
    chk("redir3_inflight", 64'(mq_due.size()), 64'd3);
    i_redirect = 1'b0; i_mem_req_ready = 1'b1;
    tick();
    chk("redir3_req_valid", {63'b0, s_req_valid}, 64'd1);
    chk("redir3_req_addr", s_req_addr, 64'h1000);
    wait_first_pop("redir3_first_pc", 64'h1000);

    // Redirect coinciding with a response and a pop.
    lat = 2;
    repeat (10) tick();
    i_redirect = 1'b1; i_redirect_pc = 64'h2000;
    tick();
    chk("combo_rsp", {63'b0, s_rsp_valid}, 64'd1);
    chk("combo_pop", {63'b0, s_instr_valid}, 64'd1);
    i_redirect = 1'b0;
    wait_first_pop("combo_first_pc", 64'h2000);

    // Memory ready 1010..., decode ready 0110..., with occasional redirects.
    npop = 0;
    for (int k = 0; k < 240; k++) begin
      i_mem_req_ready = (k % 2) == 0;
      i_instr_ready   = (k % 4) == 1 || (k % 4) == 2;
      lat             = $urandom_range(1, 3);
      i_redirect      = (k % 53) == 52;
      i_redirect_pc   = {32'h0, $urandom};
      tick();
    end
    i_redirect = 1'b0;
    chk("toggle_progress", {63'b0, npop > 40}, 64'd1);

    // Fully random traffic.
    npop = 0;
    for (int k = 0; k < 1500; k++) begin
      i_mem_req_ready = $urandom_range(0, 2) != 0;
      i_instr_ready   = $urandom_range(0, 2) != 0;
      lat             = $urandom_range(1, 5);
      i_redirect      = $urandom_range(0, 24) == 0;
      i_redirect_pc   = {$urandom, $urandom};
      tick();
    end
    i_redirect = 1'b0;
    chk("random_progress", {63'b0, npop > 200}, 64'd1);

    // Mid-stream reset pulse.
    i_mem_req_ready = 1'b1; i_instr_ready = 1'b1; lat = 2;
    repeat (10) tick();
    i_rst = 1'b1;
    tick();
    chk("midrst_req_valid", {63'b0, s_req_valid}, 64'd0);
    chk("midrst_instr_valid", {63'b0, s_instr_valid}, 64'd0);
    i_rst = 1'b0;
    tick();
    chk("postrst_req_valid", {63'b0, s_req_valid}, 64'd1);
    chk("postrst_req_addr", s_req_addr, RESET_PC);
    chk("postrst_instr_valid", {63'b0, s_instr_valid}, 64'd0);
    wait_first_pop("postrst_first_pc", RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
